// File: rtl/out_text_wrapper_if.sv
// Byte-in / beat-out stream bundle between the puts path, the line formatter
// and the view drawer.
interface out_text_wrapper_if #(
   parameter int unsigned LINE_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_char;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_char;
   logic [7:0]        out_col;
   logic              out_eol;
   logic              out_empty;
   logic [LINE_W-1:0] out_line;

   // Environment side: produces bytes, consumes beats.
   modport master (
      output in_valid, in_char, in_last, out_ready,
      input  in_ready, out_valid, out_char, out_col, out_eol, out_empty, out_line
   );

   // Formatter side: consumes bytes, produces beats.
   modport slave (
      input  in_valid, in_char, in_last, out_ready,
      output in_ready, out_valid, out_char, out_col, out_eol, out_empty, out_line
   );
endinterface

// File: rtl/out_text_wrapper.sv
// Splits the puts byte stream on newline and soft-wraps at the scrollbar column,
// emitting one registered beat per displayed character for the view drawer.
module out_text_wrapper #(
   parameter int unsigned MAX_COLS = 160,
   parameter int unsigned LINE_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic [7:0]         wrap_col,
   out_text_wrapper_if.slave  bus,
   output logic [LINE_W-1:0]  line_count
);
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_FLUSH
   } state_e;

   localparam logic [7:0] MAX_COLS_B = 8'(MAX_COLS);
   localparam logic [7:0] CH_LF      = 8'h0A;
   localparam logic [7:0] CH_CR      = 8'h0D;

   state_e            state_q, state_d;
   logic [7:0]        h_char_q, h_char_d;
   logic [7:0]        h_col_q, h_col_d;
   logic              out_valid_q, out_valid_d;
   logic [7:0]        out_char_q, out_char_d;
   logic [7:0]        out_col_q, out_col_d;
   logic              out_eol_q, out_eol_d;
   logic              out_empty_q, out_empty_d;
   logic [LINE_W-1:0] out_line_q, out_line_d;
   logic [LINE_W-1:0] line_count_q, line_count_d;

   logic [7:0] w_eff;
   logic       at_edge;
   logic       out_free;
   logic       in_fire;
   logic       beat_done;
   logic       is_lf;
   logic       is_cr;
   logic       load;
   logic [7:0] ld_char;
   logic [7:0] ld_col;
   logic       ld_eol;
   logic       ld_empty;

   assign w_eff     = (wrap_col == 8'd0 || wrap_col > MAX_COLS_B) ? MAX_COLS_B : wrap_col;
   assign at_edge   = (h_col_q >= w_eff - 8'd1);
   assign out_free  = !out_valid_q || bus.out_ready;
   assign bus.in_ready = !rst && (state_q != ST_FLUSH) && out_free;
   assign in_fire   = bus.in_valid && bus.in_ready;
   assign beat_done = out_valid_q && bus.out_ready;
   assign is_lf     = (bus.in_char == CH_LF);
   assign is_cr     = (bus.in_char == CH_CR);

   // The held char's end-of-line flag is only known once the next byte arrives.
   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_d  = state_q;
      h_char_d = h_char_q;
      h_col_d  = h_col_q;
      load     = 1'b0;
      ld_char  = h_char_q;
      ld_col   = h_col_q;
      ld_eol   = 1'b0;
      ld_empty = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_fire) begin
               if (is_lf) begin
                  load     = 1'b1;
                  ld_char  = 8'h00;
                  ld_col   = 8'd0;
                  ld_eol   = 1'b1;
                  ld_empty = 1'b1;
               end else if (!is_cr) begin
                  h_char_d = bus.in_char;
                  h_col_d  = 8'd0;
                  state_d  = bus.in_last ? ST_FLUSH : ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (in_fire) begin
               if (is_lf) begin
                  load    = 1'b1;
                  ld_eol  = 1'b1;
                  state_d = ST_IDLE;
               end else if (is_cr) begin
                  if (bus.in_last) state_d = ST_FLUSH;
               end else begin
                  load     = 1'b1;
                  ld_eol   = at_edge;
                  h_char_d = bus.in_char;
                  h_col_d  = at_edge ? 8'd0 : h_col_q + 8'd1;
                  state_d  = bus.in_last ? ST_FLUSH : ST_HOLD;
               end
            end
         end
         ST_FLUSH: begin
            if (out_free) begin
               load    = 1'b1;
               ld_eol  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new beat carries the count as it stands once any eol beat leaving now is counted.
   always_comb begin
      line_count_d = line_count_q;
      if (beat_done && out_eol_q && line_count_q != '1)
         line_count_d = line_count_q + LINE_W'(1);

      out_valid_d = out_valid_q;
      out_char_d  = out_char_q;
      out_col_d   = out_col_q;
      out_eol_d   = out_eol_q;
      out_empty_d = out_empty_q;
      out_line_d  = out_line_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_char_d  = ld_char;
         out_col_d   = ld_col;
         out_eol_d   = ld_eol;
         out_empty_d = ld_empty;
         out_line_d  = line_count_d;
      end else if (out_free) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst || clr) begin
         state_q      <= ST_IDLE;
         h_char_q     <= 8'h00;
         h_col_q      <= 8'd0;
         out_valid_q  <= 1'b0;
         out_char_q   <= 8'h00;
         out_col_q    <= 8'd0;
         out_eol_q    <= 1'b0;
         out_empty_q  <= 1'b0;
         out_line_q   <= '0;
         line_count_q <= '0;
      end else begin
         state_q      <= state_d;
         h_char_q     <= h_char_d;
         h_col_q      <= h_col_d;
         out_valid_q  <= out_valid_d;
         out_char_q   <= out_char_d;
         out_col_q    <= out_col_d;
         out_eol_q    <= out_eol_d;
         out_empty_q  <= out_empty_d;
         out_line_q   <= out_line_d;
         line_count_q <= line_count_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_char  = out_char_q;
   assign bus.out_col   = out_col_q;
   assign bus.out_eol   = out_eol_q;
   assign bus.out_empty = out_empty_q;
   assign bus.out_line  = out_line_q;
   assign line_count    = line_count_q;
endmodule

// File: tb/tb_out_text_wrapper.sv
// Scoreboarded bench for out_text_wrapper: directed text cases plus random bytes,
// checked against a line-oriented reference model.
module tb_out_text_wrapper;
   typedef struct packed {
      logic [7:0]  ch;
      logic [7:0]  col;
      logic        eol;
      logic        empty;
      logic [15:0] line;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [7:0]  wrap_col;
   logic [15:0] line_count;
   logic        rdy_mode;
   logic        ready_manual;

   int n_checks = 0;
   int n_fail   = 0;

   beat_t exp_q[$];
   int    exp_line;
   bit    m_pend;
   logic [7:0] m_char;
   int    m_col;
   bit    hold_v;
   beat_t hold_b;

   out_text_wrapper_if #(.LINE_W(16)) bus ();

   out_text_wrapper #(.MAX_COLS(160), .LINE_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .wrap_col  (wrap_col),
      .bus       (bus),
      .line_count(line_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      bus.out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : ready_manual;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   function automatic int eff_w(input logic [7:0] wc);
      return (wc == 0 || wc > 160) ? 160 : int'(wc);
   endfunction

   function automatic void push_beat(input logic [7:0] ch, input int col, input bit eol, input bit empty);
      beat_t b;
      b.ch = ch; b.col = 8'(col); b.eol = eol; b.empty = empty; b.line = 16'(exp_line);
      exp_q.push_back(b);
      if (eol) exp_line++;
   endfunction

   // Reference: a pending character is placed on its line once the next byte says whether the line ends there.
   function automatic void model_byte(input logic [7:0] c, input bit last, input int w);
      if (c == 8'h0A) begin
         if (m_pend) push_beat(m_char, m_col, 1'b1, 1'b0);
         else        push_beat(8'h00, 0, 1'b1, 1'b1);
         m_pend = 1'b0;
      end else if (c == 8'h0D) begin
         if (last && m_pend) begin
            push_beat(m_char, m_col, 1'b1, 1'b0);
            m_pend = 1'b0;
         end
      end else begin
         if (m_pend) begin
            bit line_full = (m_col >= w - 1);
            push_beat(m_char, m_col, line_full, 1'b0);
            m_col = line_full ? 0 : m_col + 1;
         end else begin
            m_col = 0;
         end
         m_char = c;
         m_pend = 1'b1;
         if (last) begin
            push_beat(m_char, m_col, 1'b1, 1'b0);
            m_pend = 1'b0;
         end
      end
   endfunction

   function automatic void model_clear();
      exp_q.delete();
      exp_line = 0;
      m_pend   = 1'b0;
      m_col    = 0;
   endfunction

   // Monitor: a beat is taken when out_valid && out_ready at the following edge.
   always @(negedge clk) begin
      if (!rst && !clr && bus.out_valid) begin
         beat_t cur;
         cur = '{bus.out_char, bus.out_col, bus.out_eol, bus.out_empty, bus.out_line};
         if (hold_v) check("stall_stable", cur, hold_b);
         if (bus.out_ready) begin
            hold_v = 1'b0;
            if (exp_q.size() == 0) check("unexpected_beat", cur, 0);
            else check("beat", cur, exp_q.pop_front());
         end else begin
            hold_v = 1'b1;
            hold_b = cur;
         end
      end else begin
         hold_v = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] c, input bit last);
      int n = 0;
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_char  = c;
      bus.in_last  = last;
      while (!ok && n < 300) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         else n++;
      end
      if (ok) model_byte(c, last, eff_w(wrap_col));
      else fail_now("in_ready_wait");
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_str(input string s, input bit last_on_end);
      for (int i = 0; i < s.len(); i++)
         send_byte(s[i], last_on_end && (i == s.len() - 1));
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_now("drain");
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      model_clear();
      hold_v = 1'b0;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wopt[8] = '{0, 1, 2, 3, 4, 5, 8, 200};
      rst = 1'b1; clr = 1'b0; wrap_col = 8'd4;
      rdy_mode = 1'b0; ready_manual = 1'b1;
      bus.in_valid = 1'b0; bus.in_char = 8'h00; bus.in_last = 1'b0;
      model_clear();
      hold_v = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_line_count", line_count, 0);
      check("rst_out_line", bus.out_line, 0);
      check("rst_in_ready_after", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // Soft wrap at column 4.
      send_str("abcdef\n", 1'b0);
      drain();
      check("wrap6_lines", line_count, 2);

      // Exactly W characters: no extra blank line.
      do_clr();
      send_str("abcd\n", 1'b0);
      drain();
      check("exact_w_lines", line_count, 1);

      // Two blank lines.
      do_clr();
      send_str("\n\n", 1'b0);
      drain();
      check("blank_lines", line_count, 2);

      // Back-pressure during FLUSH.
      do_clr();
      ready_manual = 1'b0;
      @(posedge clk);
      #1;
      send_byte("x", 1'b0);
      send_byte("y", 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("flush_in_ready", bus.in_ready, 0);
         check("flush_held_char", bus.out_char, "x");
      end
      @(posedge clk);
      #1;
      ready_manual = 1'b1;
      drain();
      check("flush_lines", line_count, 1);
      @(negedge clk);
      check("flush_in_ready_back", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // Full-width line at MAX_COLS plus one overflow character.
      do_clr();
      wrap_col = 8'd0;
      for (int i = 0; i < 161; i++) send_byte(8'("a") + 8'(i % 26), i == 160);
      drain();
      check("maxcols_lines", line_count, 2);

      // Clear mid-line with a beat stalled in the output register.
      do_clr();
      wrap_col = 8'd4;
      send_str("q\n", 1'b0);
      drain();
      check("pre_clr_lines", line_count, 1);
      ready_manual = 1'b0;
      @(posedge clk);
      #1;
      send_str("ab", 1'b0);
      @(negedge clk);
      check("pre_clr_out_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
      do_clr();
      @(negedge clk);
      check("clr_out_valid", bus.out_valid, 0);
      check("clr_line_count", line_count, 0);
      @(posedge clk);
      #1;
      ready_manual = 1'b1;
      @(posedge clk);
      #1;
      send_str("z\n", 1'b0);
      drain();
      check("post_clr_lines", line_count, 1);

      // Random bytes, random width changes and random drawer back-pressure.
      do_clr();
      rdy_mode = 1'b1;
      for (int i = 0; i < 500; i++) begin
         int r = $urandom_range(0, 15);
         logic [7:0] c;
         if ($urandom_range(0, 7) == 0) wrap_col = 8'(wopt[$urandom_range(0, 7)]);
         if (r < 2)       c = 8'h0A;
         else if (r == 2) c = 8'h0D;
         else             c = 8'("a") + 8'($urandom_range(0, 25));
         send_byte(c, $urandom_range(0, 9) == 0);
      end
      send_byte(8'h0A, 1'b1);
      drain();
      rdy_mode = 1'b0;
      check("random_lines", line_count, 16'(exp_line));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/out_text_wrapper.md
# out_text_wrapper

Streaming text-to-line formatter directly upstream of the view drawer. Accepts the byte stream written by the output `puts` path and splits it on newline (0x0A). Soft-wraps any line longer than the current scrollbar column and emits one beat per displayed character, tagged with column, end-of-line flag and output line number. The drawer consumes these beats without doing any splitting itself.

## Interface
- `MAX_COLS`, default 160: hard column limit; used when `wrap_col` is 0 or exceeds it.
- `LINE_W`, default 16: width of line counter.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `clr`  in  1  synchronous clear of line state and counter (same effect as `rst`)
- `wrap_col`  in  8  scrollbar position = max characters per displayed line
- `in_valid`  in  1  input byte valid
- `in_ready`  out  1  input byte accepted when `in_valid && in_ready`
- `in_char`  in  8  input byte
- `in_last`  in  1  final byte of a `puts` batch; terminates the current line
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  drawer accepts beat
- `out_char`  out  8  character (0x00 on empty-line beat)
- `out_col`  out  8  0-based column of `out_char`
- `out_eol`  out  1  last beat of a displayed line
- `out_empty`  out  1  beat represents a blank line
- `out_line`  out  `LINE_W`  0-based displayed-line index of this beat
- `line_count`  out  `LINE_W`  number of completed displayed lines

## Operation
- Effective width `W` = `MAX_COLS` if `wrap_col` is 0 or greater than `MAX_COLS`, else `wrap_col`. `W` is sampled at each accepted byte.
- One-character hold register H (valid, char, col) defers the EOL decision until the next byte is known. A line of exactly `W` chars is not split; a `W+1`-char line becomes `W` + 1.
- State machine with three states: IDLE (H empty), HOLD (H valid), FLUSH (one extra beat pending).
- Accepted byte, non-newline, not 0x0D:
  - IDLE: H <= {char, col 0}; no beat.
  - HOLD: emit H with `eol = (H.col >= W-1)`. H <= char with col 0 if wrapped, else H.col+1.
- Accepted 0x0A:
  - HOLD: emit H with eol=1; go to IDLE.
  - IDLE: emit blank beat (char 0x00, col 0, eol=1, empty=1).
- 0x0D is consumed with no beat and no state change.
- `in_last` with a normal char:
  - In HOLD: perform the HOLD action, then go to FLUSH.
  - From IDLE, the char is loaded into H, then FLUSH is entered.
  - FLUSH emits H with eol=1, then returns to IDLE.
- `in_last` on 0x0A: same as plain 0x0A.
- `in_last` on 0x0D: if HOLD, go to FLUSH; else no action.
- `out_line` = `line_count` at beat emission. `line_count` increments when a beat with eol=1 is accepted, and saturates at all-ones.
- `rst` or `clr`: state IDLE, H invalid, `out_valid`=0, `line_count`=0. Any in-flight beat is dropped. `clr` has priority over a same-cycle input transfer.

## Timing
- Reset values: `in_ready`=0 during reset cycle, then 1. All other outputs are 0.
- `in_ready` = (state != FLUSH) && (!`out_valid` || `out_ready`), registered-output safe, at most one beat per cycle.
- Beat appears on `out_*` the cycle after the causing byte is accepted. Output holds stable while `out_valid && !out_ready`.
- FLUSH beat issues on the first cycle the output register is free; `in_ready` returns the cycle after it is loaded.
- Full throughput: one byte in and one beat out per cycle in steady state.
- A `wrap_col` change mid-line takes effect at the next accepted byte. If H.col >= W-1, the held char is emitted with eol=1 (line ends immediately).

## Test plan
- `wrap_col`=4, bytes "abcdef\n" -> beats a0 b1 c2 d3(eol,line0) e0 f1(eol,line1); `line_count`=2.
- `wrap_col`=4, "abcd\n" -> d3 eol once, no empty line; `line_count`=1.
- "\n\n" -> two empty beats (0x00, eol=1, empty=1), `out_line` 0 then 1.
- "xy" with `in_last` on 'y', `out_ready` held 0 for 3 cycles -> x0 held stable, then y1 eol; `in_ready`=0 during FLUSH.
- `wrap_col`=0, `MAX_COLS`=160, 161 chars then `in_last` -> wrap after col 159, last char col 0 eol.
- Assert `clr` mid-line with H valid and `out_valid`=1 -> next cycle `out_valid`=0, `line_count`=0; next "z\n" yields z0 eol on line 0.
